count_seq_monitor: RTL and testbench

//  Downstream checker for the free-running WIDTH-bit wrap counter. Samples count_in every clk and verifies

---
 rtl/count_seq_monitor_pkg.sv | 21 ++
 rtl/count_seq_monitor_sat_counter.sv | 24 ++
 rtl/count_seq_monitor.sv | 121 ++++++++++++
 tb/tb_count_seq_monitor.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/count_seq_monitor_pkg.sv
// Shared types and constants for the count sequence monitor.
// Holds the FSM state encoding and the sticky error-code values.
package count_seq_monitor_pkg;

    typedef enum logic [1:0] {
        ACQ   = 2'd0,
        LOCK  = 2'd1,
        TRACK = 2'd2
    } state_t;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_STUCK = 2'b01;
    localparam logic [1:0] ERR_SKIP  = 2'b10;
    localparam logic [1:0] ERR_BOTH  = 2'b11;

    // Error-code bit contributed by a single failed step.
    function automatic logic [1:0] err_bit(input logic stuck);
        return stuck ? ERR_STUCK : ERR_SKIP;
    endfunction

endpackage

// File: rtl/count_seq_monitor_sat_counter.sv
// Saturating up-counter with synchronous active-low reset.
// Holds at all-ones instead of rolling over.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/count_seq_monitor.sv
// Checks that count_in advances by exactly +1 (mod 2^WIDTH) every clock,
// reporting lock status, wrap events, a saturating wrap tally and sticky errors.
module count_seq_monitor
    import count_seq_monitor_pkg::*;
#(
    parameter int WIDTH      = 3,
    parameter int WRAP_CNT_W = 8,
    parameter int LOCK_N     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      count_in,
    input  logic                  clr_err,
    output logic                  in_sync,
    output logic                  wrap_pulse,
    output logic [WRAP_CNT_W-1:0] wrap_count,
    output logic                  err_flag,
    output logic [1:0]            err_code,
    output logic [WIDTH-1:0]      last_good
);

    localparam int GW = (LOCK_N < 2) ? 1 : $clog2(LOCK_N + 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_last_good;
    logic [GW-1:0]    r_good_cnt;
    logic             r_in_sync;
    logic             r_wrap_pulse;
    logic             r_err_flag;
    logic [1:0]       r_err_code;

    logic             w_step_ok;
    logic             w_stuck;
    logic             w_err;
    logic             w_wrap;
    logic             w_lock_done;
    logic [1:0]       w_err_bit;

    assign w_step_ok   = (count_in == r_prev + WIDTH'(1));
    assign w_stuck     = (count_in == r_prev);
    assign w_err       = (r_state != ACQ) && !w_step_ok;
    assign w_err_bit   = err_bit(w_stuck);
    assign w_lock_done = ((int'(r_good_cnt) + 1) == LOCK_N);
    // Wrap only counts when already tracking; the tally below sees it on the same edge as the pulse.
    assign w_wrap      = (r_state == TRACK) && w_step_ok && (r_prev == '1) && (count_in == '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ACQ;
            r_prev       <= '0;
            r_last_good  <= '0;
            r_good_cnt   <= '0;
            r_in_sync    <= 1'b0;
            r_wrap_pulse <= 1'b0;
            r_err_flag   <= 1'b0;
            r_err_code   <= ERR_NONE;
        end else begin
            r_prev       <= count_in;
            r_wrap_pulse <= w_wrap;

            // A new error beats clr_err; when both coincide only the new error's bit survives.
            if (w_err) begin
                r_err_flag <= 1'b1;
                r_err_code <= clr_err ? w_err_bit : (r_err_code | w_err_bit);
            end else if (clr_err) begin
                r_err_flag <= 1'b0;
                r_err_code <= ERR_NONE;
            end

            unique case (r_state)
                ACQ: begin
                    r_good_cnt <= '0;
                    r_in_sync  <= 1'b0;
                    r_state    <= LOCK;
                end
                LOCK: begin
                    if (w_step_ok) begin
                        r_last_good <= count_in;
                        r_good_cnt  <= r_good_cnt + GW'(1);
                        if (w_lock_done) begin
                            r_state   <= TRACK;
                            r_in_sync <= 1'b1;
                        end
                    end else begin
                        r_good_cnt <= '0;
                    end
                end
                TRACK: begin
                    if (w_step_ok) begin
                        r_last_good <= count_in;
                    end else begin
                        r_in_sync  <= 1'b0;
                        r_good_cnt <= '0;
                        r_state    <= LOCK;
                    end
                end
                default: begin
                    r_state   <= ACQ;
                    r_in_sync <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(
        .W(WRAP_CNT_W)
    ) u_wrap_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_inc  (w_wrap),
        .o_count(wrap_count)
    );

    assign in_sync    = r_in_sync;
    assign wrap_pulse = r_wrap_pulse;
    assign err_flag   = r_err_flag;
    assign err_code   = r_err_code;
    assign last_good  = r_last_good;

endmodule

// File: tb/tb_count_seq_monitor.sv
// Directed and randomized checks of count_seq_monitor against a sample-history model.
// A second instance with a 2-bit wrap tally exercises saturation.
module tb_count_seq_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] count_in;
    logic       clr_err;

    logic       a_in_sync, a_wrap_pulse, a_err_flag;
    logic [7:0] a_wrap_count;
    logic [1:0] a_err_code;
    logic [2:0] a_last_good;

    logic       b_in_sync, b_wrap_pulse, b_err_flag;
    logic [1:0] b_wrap_count;
    logic [1:0] b_err_code;
    logic [2:0] b_last_good;

    int total = 0;
    int bad   = 0;

    // Model: "acquired" plus a run length of consecutive good steps; locked once run >= 2.
    bit   m_acq;
    int   m_prev;
    int   m_run;
    bit   m_sync;
    bit   m_wrap;
    bit   m_err;
    int   m_code;
    int   m_last;
    int   m_wc8;
    int   m_wc2;

    always #5 clk = ~clk;

    count_seq_monitor #(.WIDTH(3), .WRAP_CNT_W(8), .LOCK_N(2)) dut (
        .clk(clk), .rst(rst), .count_in(count_in), .clr_err(clr_err),
        .in_sync(a_in_sync), .wrap_pulse(a_wrap_pulse), .wrap_count(a_wrap_count),
        .err_flag(a_err_flag), .err_code(a_err_code), .last_good(a_last_good)
    );

    count_seq_monitor #(.WIDTH(3), .WRAP_CNT_W(2), .LOCK_N(2)) dut_sat (
        .clk(clk), .rst(rst), .count_in(count_in), .clr_err(clr_err),
        .in_sync(b_in_sync), .wrap_pulse(b_wrap_pulse), .wrap_count(b_wrap_count),
        .err_flag(b_err_flag), .err_code(b_err_code), .last_good(b_last_good)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input bit r, input int v, input bit clr);
        bit ok, stuck;
        int nb;
        if (!r) begin
            m_acq = 0; m_prev = 0; m_run = 0; m_sync = 0; m_wrap = 0;
            m_err = 0; m_code = 0; m_last = 0; m_wc8 = 0; m_wc2 = 0;
            return;
        end
        if (!m_acq) begin
            m_acq = 1; m_run = 0; m_sync = 0; m_wrap = 0;
            if (clr) begin m_err = 0; m_code = 0; end
        end else begin
            ok    = (v == (m_prev + 1) % 8);
            stuck = (v == m_prev);
            m_wrap = ok && m_sync && (m_prev == 7) && (v == 0);
            if (ok) begin
                m_run++;
                m_last = v;
                if (clr) begin m_err = 0; m_code = 0; end
            end else begin
                m_run = 0;
                nb = stuck ? 1 : 2;
                m_err = 1;
                m_code = clr ? nb : (m_code | nb);
            end
            m_sync = (m_run >= 2);
        end
        m_prev = v;
        if (m_wrap) begin
            if (m_wc8 < 255) m_wc8++;
            if (m_wc2 < 3) m_wc2++;
        end
    endtask

    task automatic step(input int v, input bit clr, input bit r);
        count_in = 3'(v);
        clr_err  = clr;
        rst      = r;
        @(posedge clk);
        model(r, v, clr);
        #1;
        chk("in_sync",    32'(a_in_sync),    32'(m_sync));
        chk("wrap_pulse", 32'(a_wrap_pulse), 32'(m_wrap));
        chk("wrap_count", 32'(a_wrap_count), 32'(m_wc8));
        chk("err_flag",   32'(a_err_flag),   32'(m_err));
        chk("err_code",   32'(a_err_code),   32'(m_code));
        chk("last_good",  32'(a_last_good),  32'(m_last));
        chk("sat_wrap_count", 32'(b_wrap_count), 32'(m_wc2));
        chk("sat_in_sync",    32'(b_in_sync),    32'(m_sync));
    endtask

    initial begin
        int c;
        int pulses;
        int r;
        rst = 1'b0; count_in = '0; clr_err = 1'b0;

        // 1: reset, then lock on 0,1,2
        step(5, 0, 0);
        step(3, 1, 0);
        chk("reset_in_sync", 32'(a_in_sync), 32'd0);
        chk("reset_err_code", 32'(a_err_code), 32'd0);
        step(0, 0, 1);
        chk("t1_sync_after0", 32'(a_in_sync), 32'd0);
        step(1, 0, 1);
        chk("t1_sync_after1", 32'(a_in_sync), 32'd0);
        step(2, 0, 1);
        chk("t1_sync_after2", 32'(a_in_sync), 32'd1);
        chk("t1_err_flag", 32'(a_err_flag), 32'd0);

        // 2: 17 clean samples 3..7,0..7,0..3
        c = 3; pulses = 0;
        for (int i = 0; i < 17; i++) begin
            step(c, 0, 1);
            if (a_wrap_pulse) pulses++;
            c = (c + 1) % 8;
        end
        chk("t2_pulses", 32'(pulses), 32'd2);
        chk("t2_wrap_count", 32'(a_wrap_count), 32'd2);
        chk("t2_last_good", 32'(a_last_good), 32'd3);

        // 3: stuck 4,5,5,6,7
        step(4, 0, 1);
        step(5, 0, 1);
        step(5, 0, 1);
        chk("t3_err_flag", 32'(a_err_flag), 32'd1);
        chk("t3_err_code", 32'(a_err_code), 32'd1);
        chk("t3_in_sync", 32'(a_in_sync), 32'd0);
        step(6, 0, 1);
        chk("t3_sync_after6", 32'(a_in_sync), 32'd0);
        step(7, 0, 1);
        chk("t3_sync_after7", 32'(a_in_sync), 32'd1);

        // 4: skip 2->4 accumulates, then clear on clean step
        step(0, 0, 1);
        step(1, 0, 1);
        step(2, 0, 1);
        step(4, 0, 1);
        chk("t4_err_code_both", 32'(a_err_code), 32'd3);
        step(5, 1, 1);
        chk("t4_clr_flag", 32'(a_err_flag), 32'd0);
        chk("t4_clr_code", 32'(a_err_code), 32'd0);

        // 5: clr_err coincident with skip 6->0
        step(6, 0, 1);
        step(0, 1, 1);
        chk("t5_err_flag", 32'(a_err_flag), 32'd1);
        chk("t5_err_code", 32'(a_err_code), 32'd2);
        chk("t5_no_wrap", 32'(a_wrap_pulse), 32'd0);

        // 6: saturation of the 2-bit tally, then mid-run reset
        step(0, 0, 0);
        c = 0;
        for (int i = 0; i < 60; i++) begin
            step(c, 0, 1);
            c = (c + 1) % 8;
        end
        chk("t6_sat_hold", 32'(b_wrap_count), 32'd3);
        chk("t6_wide_count", 32'(a_wrap_count), 32'd7);
        step(c, 1, 0);
        chk("t6_rst_count", 32'(a_wrap_count), 32'd0);
        chk("t6_rst_last", 32'(a_last_good), 32'd0);
        chk("t6_rst_flag", 32'(a_err_flag), 32'd0);

        // Random phase: mostly clean counting with injected faults, clears and resets
        c = 0;
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 6)       c = c;
            else if (r < 12) c = int'($urandom_range(0, 7));
            else             c = (c + 1) % 8;
            step(c, ($urandom_range(0, 9) == 0), ($urandom_range(0, 149) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
